// File: rtl/conv_seq_pkg.sv
// Shared state encoding, default widths and warm-up helper for the conv memory sequencer.
package conv_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_KLOAD = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   localparam int DEF_BIT_LEN    = 8;
   localparam int DEF_RAM_WIDTH  = 13;
   localparam int DEF_NB_ADDRESS = 10;
   localparam int DEF_M_LEN      = 3;

   // The first M_LEN-1 columns only fill the Conv window and produce no result.
   function automatic int conv_seq_warmup(input int m_len);
      return m_len - 1;
   endfunction

   localparam int WARMUP = conv_seq_warmup(DEF_M_LEN);

endpackage

// File: rtl/conv_seq_tag_pipe.sv
// CONV_LAT-deep shift register of {valid, column} tags that tracks columns in flight through Conv.
module conv_seq_tag_pipe #(
   parameter int CONV_LAT   = 2,
   parameter int NB_ADDRESS = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_vld_i,
   input  logic [NB_ADDRESS-1:0] in_col_i,
   output logic                  out_vld_o,
   output logic [NB_ADDRESS-1:0] out_col_o,
   output logic                  empty_o
);

   logic [CONV_LAT-1:0]   vld_q;
   logic [NB_ADDRESS-1:0] col_q [CONV_LAT];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= '0;
         for (int i = 0; i < CONV_LAT; i++) col_q[i] <= '0;
      end else begin
         for (int i = CONV_LAT-1; i > 0; i--) begin
            vld_q[i] <= vld_q[i-1];
            col_q[i] <= col_q[i-1];
         end
         vld_q[0] <= in_vld_i;
         col_q[0] <= in_col_i;
      end
   end

   assign out_vld_o = vld_q[CONV_LAT-1];
   assign out_col_o = col_q[CONV_LAT-1];

   // Empty means nothing behind the exit stage; the exiting tag retires on this edge.
   always_comb begin
      empty_o = 1'b1;
      for (int i = 0; i < CONV_LAT-1; i++) empty_o = empty_o & ~vld_q[i];
   end

endmodule

// File: rtl/conv_mem_sequencer.sv
// Kernel-load / image-stream sequencer between GPIO, Conv and M_LEN column BRAMs; results written back
// 2+CONV_LAT cycles after each read issue. Optional RUN stall via CONV_SEQ_PAUSE_EN (adds i_pause).
module conv_mem_sequencer
   import conv_seq_pkg::*;
#(
   parameter int BIT_LEN    = DEF_BIT_LEN,
   parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
   parameter int NB_ADDRESS = DEF_NB_ADDRESS,
   parameter int M_LEN      = DEF_M_LEN,
   parameter int CONV_LAT   = 2
) (
   input  logic                       CLK100MHZ,
   input  logic                       i_reset,
   input  logic                       i_kload,
   input  logic                       i_kernel_valid,
   input  logic [M_LEN*BIT_LEN-1:0]   i_kernel_data,
   input  logic                       i_start,
   input  logic [NB_ADDRESS-1:0]      i_length,
   input  logic [M_LEN*RAM_WIDTH-1:0] i_mem_data,
   input  logic [RAM_WIDTH-1:0]       i_conv_data,
`ifdef CONV_SEQ_PAUSE_EN
   input  logic                       i_pause,
`endif
   output logic [NB_ADDRESS-1:0]      o_read_add,
   output logic [NB_ADDRESS-1:0]      o_write_add,
   output logic                       o_wr_enable,
   output logic [RAM_WIDTH-1:0]       o_wr_data,
   output logic [M_LEN*BIT_LEN-1:0]   o_conv_data,
   output logic                       o_conv_selK_I,
   output logic                       o_conv_valid,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam int KC_W = $clog2(M_LEN + 1);
   localparam logic [NB_ADDRESS-1:0] WARM_A = NB_ADDRESS'(conv_seq_warmup(M_LEN));

   seq_state_t                state_q;
   logic [KC_W-1:0]           kcount_q;
   logic [NB_ADDRESS-1:0]     len_q;
   logic [NB_ADDRESS-1:0]     read_add_q;
   logic [M_LEN*BIT_LEN-1:0]  kdata_q;
   logic                      tag_vld_q;
   logic [NB_ADDRESS-1:0]     tag_col_q;
   logic                      pipe_out_vld;
   logic [NB_ADDRESS-1:0]     pipe_out_col;
   logic                      pipe_empty;
   logic                      exit_write_d;
   logic                      run_adv_d;
   logic [M_LEN*BIT_LEN-1:0]  mem_samples;
   logic                      unused_mem_bits;

`ifdef CONV_SEQ_PAUSE_EN
   assign run_adv_d = (state_q == ST_RUN) && !i_pause;
`else
   assign run_adv_d = (state_q == ST_RUN);
`endif

   assign exit_write_d = pipe_out_vld && (pipe_out_col >= WARM_A);

   for (genvar c = 0; c < M_LEN; c++) begin : g_samp
      assign mem_samples[c*BIT_LEN +: BIT_LEN] = i_mem_data[c*RAM_WIDTH +: BIT_LEN];
   end
   // Only the low BIT_LEN bits of each BRAM word feed Conv.
   assign unused_mem_bits = ^i_mem_data;

   // Image samples bypass the register so Conv sees BRAM data the cycle it arrives.
   assign o_conv_data = tag_vld_q ? mem_samples : kdata_q;
   assign o_read_add  = read_add_q;

   conv_seq_tag_pipe #(
      .CONV_LAT   (CONV_LAT),
      .NB_ADDRESS (NB_ADDRESS)
   ) u_tag_pipe (
      .clk_i     (CLK100MHZ),
      .rst_i     (i_reset),
      .in_vld_i  (tag_vld_q),
      .in_col_i  (tag_col_q),
      .out_vld_o (pipe_out_vld),
      .out_col_o (pipe_out_col),
      .empty_o   (pipe_empty)
   );

   always_ff @(posedge CLK100MHZ) begin
      if (i_reset) begin
         state_q       <= ST_IDLE;
         kcount_q      <= '0;
         len_q         <= '0;
         read_add_q    <= '0;
         kdata_q       <= '0;
         tag_vld_q     <= 1'b0;
         tag_col_q     <= '0;
         o_write_add   <= '0;
         o_wr_enable   <= 1'b0;
         o_wr_data     <= '0;
         o_conv_selK_I <= 1'b0;
         o_conv_valid  <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
      end else begin
         o_conv_valid <= 1'b0;
         tag_vld_q    <= 1'b0;
         o_wr_enable  <= exit_write_d;
         if (exit_write_d) begin
            o_write_add <= pipe_out_col - WARM_A;
            o_wr_data   <= i_conv_data;
         end

         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (i_kload) begin
                  state_q  <= ST_KLOAD;
                  kcount_q <= '0;
                  o_busy   <= 1'b1;
                  o_done   <= 1'b0;
               end else if (i_start) begin
                  len_q <= i_length;
                  if (i_length == '0) begin
                     state_q <= ST_DONE;
                     o_done  <= 1'b1;
                  end else begin
                     state_q    <= ST_RUN;
                     read_add_q <= '0;
                     o_busy     <= 1'b1;
                     o_done     <= 1'b0;
                  end
               end
            end
            ST_KLOAD: begin
               if (i_kernel_valid) begin
                  o_conv_valid  <= 1'b1;
                  o_conv_selK_I <= 1'b0;
                  kdata_q       <= i_kernel_data;
                  if (kcount_q == KC_W'(M_LEN - 1)) begin
                     state_q <= ST_IDLE;
                     o_busy  <= 1'b0;
                  end else begin
                     kcount_q <= kcount_q + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (run_adv_d) begin
                  o_conv_valid  <= 1'b1;
                  o_conv_selK_I <= 1'b1;
                  tag_vld_q     <= 1'b1;
                  tag_col_q     <= read_add_q;
                  if (read_add_q == NB_ADDRESS'(len_q - 1'b1)) state_q <= ST_DRAIN;
                  else read_add_q <= read_add_q + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (!tag_vld_q && pipe_empty) begin
                  state_q <= ST_DONE;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/conv_mem_sequencer.md
Name: conv_mem_sequencer

Overview:
- Parametrised address/control sequencer between the micro's GPIO, the Conv block and M_LEN bram_memory column buffers.
- Loads an M_LEN-column kernel from the micro, then streams image columns from the BRAMs into Conv.
- Writes each valid convolution result back to the result BRAM at a latency-compensated address.
- Raises done when the run completes; the micro owns no address counters.

Parameters:
- BIT_LEN, 8, data sample width fed to Conv
- RAM_WIDTH, 13, BRAM word / Conv output width
- NB_ADDRESS, 10, BRAM address width
- M_LEN, 3, channel count (kernel columns = BRAMs read in parallel); ≥2
- CONV_LAT, 2, Conv input-valid to o_data latency in cycles; ≥1

Ports:
- CLK100MHZ  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_kload  in  1  pulse; enter kernel-load from IDLE
- i_kernel_valid  in  1  kernel column present
- i_kernel_data  in  M_LEN*BIT_LEN  kernel column, channel 0 in LSBs
- i_start  in  1  pulse; start run from IDLE
- i_length  in  NB_ADDRESS  number of image columns to read; sampled on start
- i_mem_data  in  M_LEN*RAM_WIDTH  BRAM read data (1-cycle read latency)
- i_conv_data  in  RAM_WIDTH  Conv o_data
- o_read_add  out  NB_ADDRESS  shared BRAM read address
- o_write_add  out  NB_ADDRESS  result BRAM write address
- o_wr_enable  out  1  result BRAM write strobe
- o_wr_data  out  RAM_WIDTH  result BRAM write data
- o_conv_data  out  M_LEN*BIT_LEN  Conv input samples
- o_conv_selK_I  out  1  0 = kernel, 1 = image
- o_conv_valid  out  1  Conv i_valid
- o_busy  out  1  state ≠ IDLE/DONE
- o_done  out  1  run finished

Behaviour:
- All outputs registered except o_conv_data in RUN.
- Reset (sync, any state incl. mid-run) → IDLE; all outputs 0; tag pipeline flushed.
- States: IDLE, KLOAD, RUN, DRAIN, DONE.
- IDLE:
  - i_kload → KLOAD.
  - else i_start → RUN.
  - Both asserted → KLOAD wins.
- KLOAD:
  - each i_kernel_valid cycle → next cycle o_conv_valid=1, o_conv_selK_I=0, o_conv_data=i_kernel_data (registered).
  - kcount increments per valid column; after M_LEN columns → IDLE.
  - i_start ignored.
- RUN:
  - len latched at start; col counter 0..len-1, o_read_add=col, one address per cycle.
  - Cycle after issuing col k: o_conv_valid=1, selK_I=1, o_conv_data[c]=i_mem_data[c*RAM_WIDTH +: BIT_LEN] (combinational); tag k enters shift pipe.
  - After issuing len-1 → DRAIN.
  - len=0 → DONE directly, no reads.
- Tag pipe:
  - depth CONV_LAT carries {valid,col}.
  - On exit tag k with k ≥ M_LEN-1, next cycle: o_wr_enable=1, o_write_add=k-(M_LEN-1), o_wr_data=i_conv_data sampled at exit.
  - Tags k < M_LEN-1 are warm-up: no write.
  - Last write occurs 2+CONV_LAT cycles after last read issue.
- DRAIN: wait until pipe empty and final write issued → DONE.
- DONE: o_done=1, held until i_start (→ RUN, o_done cleared same edge), i_kload (→ KLOAD) or reset.
- Writes per run = max(0, len-(M_LEN-1)).
- Address counters never wrap within a run (len ≤ 2^NB_ADDRESS-1).
- i_start/i_kload while busy ignored.
- o_read_add holds last value outside RUN.

Optional Feature:
- Macro CONV_SEQ_PAUSE_EN.
- Defined:
  - adds port i_pause (in, 1).
  - While i_pause=1 in RUN: col counter and o_read_add hold, no tag enters pipe, o_conv_valid=0 next cycle.
  - Pipe and DRAIN continue.
  - i_pause ignored in other states.
- Undefined: no port; RUN never stalls.

Decomposition:
- Package conv_seq_pkg: state encoding (IDLE..DONE); default widths BIT_LEN/RAM_WIDTH/NB_ADDRESS/M_LEN; helper constant WARMUP=M_LEN-1.
- One sub-module: conv_seq_tag_pipe (parametrised CONV_LAT shift register of {valid, NB_ADDRESS col}, with flush on reset and empty flag).

Test Plan:
- Reset mid-RUN at col 5 (len=20) → next cycle IDLE, o_wr_enable=0, o_busy=0, pipe empty, subsequent start writes from address 0.
- KLOAD with 3 valid columns 0x94/0x00/0x00 separated by idle gaps → exactly 3 o_conv_valid pulses with selK_I=0 and matching data, return to IDLE.
- Run len=38, M_LEN=3, CONV_LAT=2, Conv model = sum of inputs → 36 writes, addresses 0..35, first write 4 cycles after read 2 issued, o_done 4 cycles after read 37.
- len=2 (<M_LEN) → 2 reads, zero writes, DONE. len=0 → DONE next cycle, no reads.
- i_start pulses during RUN and DRAIN → ignored; restart from DONE with len=5 → o_done drops same edge, 3 writes.
- With CONV_SEQ_PAUSE_EN, i_pause high 4 cycles at col 10 → read address holds 10, o_conv_valid low 4 cycles, write sequence unbroken, total writes unchanged.
